// File: rtl/vo_pkg.sv
// Shared types and beat formatting for the feature packer: the FIFO entry layout,
// the packet FSM states and the helpers that turn an entry into 32-bit beats.
package vo_pkg;

  localparam int         BEATS_PER_FEAT = 10;
  localparam logic [7:0] HDR1_MARKER    = 8'hFE;
  localparam int         SEQ_BITS       = 16;

  typedef struct packed {
    logic [9:0]          coor_x;
    logic [9:0]          coor_y;
    logic [7:0]          score;
    logic [9:0]          depth;
    logic [255:0]        desc;
    logic [SEQ_BITS-1:0] seq;
  } feature_t;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DESC} pack_state_e;

  function automatic logic [31:0] hdr0_word(feature_t f);
    return {2'b00, f.depth, f.coor_y, f.coor_x};
  endfunction

  function automatic logic [31:0] hdr1_word(feature_t f);
    return {HDR1_MARKER, f.seq, f.score};
  endfunction

  // Descriptor words go out least-significant word first.
  function automatic logic [31:0] desc_word(feature_t f, logic [2:0] k);
    return f.desc[32*k +: 32];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; also exposes the entry behind the head
// so the packer can start the next packet on the same edge that pops the current one.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;

  // NOTE: storage is deliberately left out of reset; the pointers and count alone
  // define which entries are live, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every register here is assigned with <= so all state updates see the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // The caller only pushes into a full FIFO in a cycle that also pops.
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_nxt];

endmodule

// File: rtl/feature_packer.sv
// Buffers flagged features in a FIFO and streams each one as a 10-beat
// valid/ready packet: two header beats followed by eight descriptor words.
module feature_packer
  import vo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OUT_W = 32,
  parameter int SEQ_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_frame_start,
  input  logic                     i_flag,
  input  logic [9:0]               i_coor_x,
  input  logic [9:0]               i_coor_y,
  input  logic [7:0]               i_score,
  input  logic [9:0]               i_depth,
  input  logic [255:0]             i_descriptor,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_last,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_cnt,
  output logic [$clog2(DEPTH):0]   o_fifo_cnt
);

  localparam int         CW        = $clog2(DEPTH) + 1;
  localparam logic [2:0] LAST_DESC = 3'(BEATS_PER_FEAT - 3);

  pack_state_e    state;
  logic [2:0]     beat;
  logic [SEQ_W-1:0] seq;
  feature_t       wr_entry;
  feature_t       head;
  feature_t       head_next;
  feature_t       next_entry;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           accept;
  logic           pop;
  logic           push;
  logic           drop;
  logic           more;

  always_comb begin
    // NOTE: a full default first keeps every field driven on every pass, so no
    // latch can be inferred even if a field assignment is later made conditional.
    wr_entry        = '0;
    wr_entry.coor_x = i_coor_x;
    wr_entry.coor_y = i_coor_y;
    wr_entry.score  = i_score;
    wr_entry.depth  = i_depth;
    wr_entry.desc   = i_descriptor;
    wr_entry.seq    = i_frame_start ? '0 : SEQ_BITS'(seq);
  end

  assign accept = o_valid && i_ready;
  assign pop    = accept && (state == DESC) && (beat == LAST_DESC);
  assign push   = i_flag && (!full || pop);
  assign drop   = i_flag && !push;

  // After a pop the new head is the entry behind it, or the one being written now.
  assign more       = (count[CW-1:1] != '0) || push;
  assign next_entry = (count[CW-1:1] != '0) ? head_next : wr_entry;
  assign o_fifo_cnt = count;

  sync_fifo #(
    .WIDTH ($bits(feature_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .pop       (pop),
    .wr_data   (wr_entry),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head),
    .head_next (head_next)
  );

  // A drop coinciding with a frame start is counted against the new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seq        <= '0;
      o_drop_cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)               seq <= i_frame_start ? SEQ_W'(1) : seq + 1'b1;
      else if (i_frame_start) seq <= '0;

      if (i_frame_start) begin
        o_drop_cnt <= drop ? 8'd1 : 8'd0;
        o_overflow <= drop;
      end else if (drop) begin
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 1'b1;
        o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      beat    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state   <= HDR0;
          o_valid <= 1'b1;
          o_data  <= hdr0_word(head);
        end
        HDR0: if (accept) begin
          state  <= HDR1;
          o_data <= hdr1_word(head);
        end
        HDR1: if (accept) begin
          state  <= DESC;
          beat   <= '0;
          o_data <= desc_word(head, 3'd0);
        end
        DESC: if (accept) begin
          if (beat == LAST_DESC) begin
            o_last <= 1'b0;
            if (more) begin
              state  <= HDR0;
              o_data <= hdr0_word(next_entry);
            end else begin
              state   <= IDLE;
              o_valid <= 1'b0;
              o_data  <= '0;
            end
          end else begin
            beat   <= beat + 1'b1;
            o_data <= desc_word(head, beat + 1'b1);
            o_last <= (beat + 1'b1 == LAST_DESC);
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_packer.sv
// Scoreboard bench for feature_packer: stimulus queues expected beats, a monitor
// pops and compares them on every accepted beat and checks stall stability.
module tb_feature_packer;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_frame_start = 1'b0;
  logic           i_flag = 1'b0;
  logic           i_ready = 1'b0;
  logic [9:0]     i_coor_x = '0;
  logic [9:0]     i_coor_y = '0;
  logic [7:0]     i_score = '0;
  logic [9:0]     i_depth = '0;
  logic [255:0]   i_descriptor = '0;
  logic           o_valid;
  logic [31:0]    o_data;
  logic           o_last;
  logic           o_overflow;
  logic [7:0]     o_drop_cnt;
  logic [CW-1:0]  o_fifo_cnt;

  int          checks = 0;
  int          errors = 0;
  int          exp_seq = 0;
  logic [32:0] exp_q[$];

  logic        stalled = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;
  logic [32:0] exp_beat;
  bit          found;
  int          n_valid;
  logic [31:0] d3_word;

  feature_packer #(.DEPTH(DEPTH), .OUT_W(32), .SEQ_W(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_frame_start (i_frame_start),
    .i_flag        (i_flag),
    .i_coor_x      (i_coor_x),
    .i_coor_y      (i_coor_y),
    .i_score       (i_score),
    .i_depth       (i_depth),
    .i_descriptor  (i_descriptor),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_last        (o_last),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt),
    .o_fifo_cnt    (o_fifo_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic set_fields(input int idx);
    i_coor_x = 10'(idx * 37 + 3);
    i_coor_y = 10'(idx * 91 + 7);
    i_score  = 8'(idx * 13 + 1);
    i_depth  = 10'(idx * 53 + 11);
    for (int k = 0; k < 8; k++)
      i_descriptor[32*k +: 32] = {8'(idx), 8'(k), 16'hBE00 + 16'(idx)};
  endtask

  // Expected packet for the fields currently on the inputs, with the model's seq.
  task automatic push_expected();
    exp_q.push_back({1'b0, (32'(i_depth) << 20) | (32'(i_coor_y) << 10) | 32'(i_coor_x)});
    exp_q.push_back({1'b0, 32'hFE00_0000 | (32'(exp_seq[15:0]) << 8) | 32'(i_score)});
    for (int k = 0; k < 8; k++)
      exp_q.push_back({k == 7, i_descriptor[32*k +: 32]});
    exp_seq++;
  endtask

  task automatic drive_feature(input int idx, input bit kept);
    set_fields(idx);
    i_flag = 1'b1;
    if (kept) push_expected();
    @(posedge i_clk);
    #1 i_flag = 1'b0;
  endtask

  task automatic pulse_frame_start();
    i_frame_start = 1'b1;
    exp_seq = 0;
    @(posedge i_clk);
    #1 i_frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    bit done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_valid && o_fifo_cnt == '0) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: compares accepted beats against the scoreboard and checks held beats.
  initial begin : monitor
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 32'(o_valid), 32'd1);
          check("stall_data", o_data, held_data);
          check("stall_last", 32'(o_last), 32'(held_last));
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %08h expected no beat", o_data);
          end else begin
            exp_beat = exp_q.pop_front();
            check("beat_data", o_data, exp_beat[31:0]);
            check("beat_last", 32'(o_last), 32'(exp_beat[32]));
          end
        end
        stalled   = o_valid && !i_ready;
        held_data = o_data;
        held_last = o_last;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
    check("rst_fifo_cnt", 32'(o_fifo_cnt), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Single hand-computed feature, consumer always ready.
    i_ready      = 1'b1;
    i_coor_x     = 10'd100;
    i_coor_y     = 10'd50;
    i_score      = 8'h3C;
    i_depth      = 10'd512;
    i_descriptor = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    i_flag       = 1'b1;
    exp_q.push_back({1'b0, 32'h2000_C864});
    exp_q.push_back({1'b0, 32'hFE00_003C});
    exp_q.push_back({1'b0, 32'hCCDD_EEFF});
    exp_q.push_back({1'b0, 32'h8899_AABB});
    exp_q.push_back({1'b0, 32'h4455_6677});
    exp_q.push_back({1'b0, 32'h0011_2233});
    exp_q.push_back({1'b0, 32'h7654_3210});
    exp_q.push_back({1'b0, 32'hFEDC_BA98});
    exp_q.push_back({1'b0, 32'h89AB_CDEF});
    exp_q.push_back({1'b1, 32'h0123_4567});
    exp_seq = 1;
    @(posedge i_clk);
    #1 i_flag = 1'b0;
    check("latency_valid_t", 32'(o_valid), 32'd0);
    check("latency_fifo_cnt", 32'(o_fifo_cnt), 32'd1);
    @(posedge i_clk);
    #1;
    check("latency_valid_t1", 32'(o_valid), 32'd1);
    check("hdr0_direct", o_data, 32'h2000_C864);
    wait_idle(40, "single_drain");

    // Backpressure: ready low in the first valid cycle, then alternating.
    i_ready = 1'b0;
    drive_feature(5, 1'b1);
    n_valid = 0;
    for (int c = 0; c < 30; c++) begin
      i_ready = !c[0];
      @(negedge i_clk);
      if (o_valid) n_valid++;
      @(posedge i_clk);
      #1;
    end
    check("bp_valid_cycles", 32'(n_valid), 32'd20);
    i_ready = 1'b1;
    wait_idle(20, "bp_drain");

    // Burst of 20 into a stalled output: 16 kept with seq 0..15, 4 dropped.
    pulse_frame_start();
    i_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_feature(20 + i, i < 16);
    check("burst_fifo_cnt", 32'(o_fifo_cnt), 32'd16);
    check("burst_drop_cnt", 32'(o_drop_cnt), 32'd4);
    check("burst_overflow", 32'(o_overflow), 32'd1);

    // Frame start clears the drop status but keeps the queued entries.
    pulse_frame_start();
    check("fs_drop_cnt", 32'(o_drop_cnt), 32'd0);
    check("fs_overflow", 32'(o_overflow), 32'd0);
    check("fs_fifo_cnt", 32'(o_fifo_cnt), 32'd16);

    // Full FIFO: a feature arriving with the D7 accept takes the freed slot.
    i_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge i_clk);
      if (o_valid && o_last) found = 1'b1;
    end
    check("d7_reached", 32'(found), 32'd1);
    set_fields(50);
    i_flag = 1'b1;
    push_expected();
    @(posedge i_clk);
    #1 i_flag = 1'b0;
    check("fullpop_fifo_cnt", 32'(o_fifo_cnt), 32'd16);
    check("fullpop_drop_cnt", 32'(o_drop_cnt), 32'd0);
    check("fullpop_overflow", 32'(o_overflow), 32'd0);
    wait_idle(16 * 10 + 40, "burst_drain");

    // Frame start together with a flag: that feature gets seq 0, the next seq 1.
    set_fields(60);
    i_flag = 1'b1;
    i_frame_start = 1'b1;
    exp_seq = 0;
    push_expected();
    @(posedge i_clk);
    #1 i_frame_start = 1'b0;
    set_fields(61);
    push_expected();
    @(posedge i_clk);
    #1 i_flag = 1'b0;
    wait_idle(40, "fs_flag_drain");

    // Reset during D3 aborts the packet; a fresh feature then streams from HDR0.
    set_fields(70);
    d3_word = i_descriptor[127:96];
    i_flag = 1'b1;
    push_expected();
    @(posedge i_clk);
    #1 i_flag = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge i_clk);
      if (o_valid && o_data == d3_word) found = 1'b1;
    end
    check("d3_reached", 32'(found), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_fifo_cnt", 32'(o_fifo_cnt), 32'd0);
    check("mid_rst_last", 32'(o_last), 32'd0);
    exp_q.delete();
    exp_seq = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("post_rst_valid", 32'(o_valid), 32'd0);
    drive_feature(71, 1'b1);
    wait_idle(40, "post_rst_drain");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
